adder_tree_scheduler: RTL and testbench

Round-robin scheduler sharing one pipelined 7-input-plus-bias fixed-point adder tree among several neuron requesters. It grants at most one request per cycle and registers the winner's operands onto the tree input bus. It tracks each in-flight operation's requester ID alongside the tree pipeline and returns the finished sum tagged with that ID. It also bounds per-requester outstanding work and provides a drain handshake for layer switches.

---
 rtl/adder_tree_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_adder_tree_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_scheduler.sv
// Round-robin scheduler that shares one pipelined 7-operand-plus-bias adder tree
// among several requesters and returns each finished sum tagged with its owner.
module adder_tree_scheduler #(
  parameter int DW       = 26,
  parameter int NUM_IN   = 7,
  parameter int NUM_REQ  = 4,
  parameter int TREE_LAT = 6,
  parameter int MAX_OUT  = 4,
  localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         GlobalReset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*NUM_IN*DW-1:0] req_operands,
  input  logic [NUM_REQ*DW-1:0]        req_beta,
  output logic [NUM_REQ-1:0]           req_grant,
  output logic [NUM_IN*DW-1:0]         tree_operands,
  output logic [DW-1:0]                tree_beta,
  output logic                         tree_valid,
  input  logic [DW-1:0]                tree_result,
  output logic                         rsp_valid,
  output logic [IDW-1:0]               rsp_id,
  output logic [DW-1:0]                rsp_data,
  input  logic                         drain,
  output logic                         drain_done,
  output logic                         busy
);

  localparam int OPW = NUM_IN * DW;
  localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t              r_state;
  logic [IDW-1:0]      r_ptr;
  logic [IDW-1:0]      r_issueId;
  logic [OPW-1:0]      r_treeOps;
  logic [DW-1:0]       r_treeBeta;
  logic                r_treeValid;
  logic [TREE_LAT-1:0] r_tagValid;
  logic [IDW-1:0]      r_tagId [TREE_LAT];
  logic                r_rspValid;
  logic [IDW-1:0]      r_rspId;
  logic [DW-1:0]       r_rspData;
  logic [3:0]          r_outCnt [NUM_REQ];
  logic                r_busy;
  logic                r_drainDone;

  logic [NUM_REQ-1:0]  w_eligible;
  logic [NUM_REQ-1:0]  w_grant;
  logic                w_anyGrant;
  logic [IDW-1:0]      w_grantId;
  logic [IDW-1:0]      w_ptrNext;
  logic [OPW-1:0]      w_selOps;
  logic [DW-1:0]       w_selBeta;
  logic [3:0]          w_cntNext [NUM_REQ];
  logic                w_anyOut;
  logic                w_allIdle;

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_eligible[i] = req_valid[i] && (r_outCnt[i] < MAX_CNT) && (r_state == ST_RUN) && !drain;
    end
  end

  // First eligible requester at or after the pointer wins, wrapping around.
  always_comb begin
    int idx;
    idx        = 0;
    w_grant    = '0;
    w_anyGrant = 1'b0;
    w_grantId  = '0;
    w_selOps   = '0;
    w_selBeta  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_anyGrant && w_eligible[idx]) begin
        w_anyGrant   = 1'b1;
        w_grantId    = IDW'(idx);
        w_grant[idx] = 1'b1;
        w_selOps     = req_operands[idx*OPW +: OPW];
        w_selBeta    = req_beta[idx*DW +: DW];
      end
    end
  end

  assign w_ptrNext = (w_grantId == IDW'(NUM_REQ - 1)) ? '0 : w_grantId + IDW'(1);

  always_comb begin
    w_anyOut  = 1'b0;
    w_allIdle = !r_treeValid && (r_tagValid == '0);
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cntNext[i] = r_outCnt[i];
      if (w_grant[i] && !(r_rspValid && r_rspId == IDW'(i)))
        w_cntNext[i] = r_outCnt[i] + 4'd1;
      else if (!w_grant[i] && r_rspValid && r_rspId == IDW'(i))
        w_cntNext[i] = r_outCnt[i] - 4'd1;
      if (w_cntNext[i] != 4'd0) w_anyOut = 1'b1;
      if (r_outCnt[i] != 4'd0) w_allIdle = 1'b0;
    end
  end

  // Issue registers, tag pipeline running alongside the tree, and response capture.
  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_ptr       <= '0;
      r_issueId   <= '0;
      r_treeOps   <= '0;
      r_treeBeta  <= '0;
      r_treeValid <= 1'b0;
      r_tagValid  <= '0;
      for (int s = 0; s < TREE_LAT; s++) r_tagId[s] <= '0;
      r_rspValid  <= 1'b0;
      r_rspId     <= '0;
      r_rspData   <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_outCnt[i] <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_treeValid <= w_anyGrant;
      if (w_anyGrant) begin
        r_treeOps  <= w_selOps;
        r_treeBeta <= w_selBeta;
        r_issueId  <= w_grantId;
        r_ptr      <= w_ptrNext;
      end
      r_tagValid[0] <= r_treeValid;
      r_tagId[0]    <= r_issueId;
      for (int s = 1; s < TREE_LAT; s++) begin
        r_tagValid[s] <= r_tagValid[s-1];
        r_tagId[s]    <= r_tagId[s-1];
      end
      r_rspValid <= r_tagValid[TREE_LAT-1];
      if (r_tagValid[TREE_LAT-1]) begin
        r_rspId   <= r_tagId[TREE_LAT-1];
        r_rspData <= tree_result;
      end
      for (int i = 0; i < NUM_REQ; i++) r_outCnt[i] <= w_cntNext[i];
      r_busy <= w_anyOut;
    end
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      r_state     <= ST_RUN;
      r_drainDone <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (drain) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!drain) begin
            r_state <= ST_RUN;
          end else if (w_allIdle) begin
            r_state     <= ST_DONE;
            r_drainDone <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!drain) begin
            r_state     <= ST_RUN;
            r_drainDone <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_RUN;
          r_drainDone <= 1'b0;
        end
      endcase
    end
  end

  assign req_grant     = w_grant;
  assign tree_operands = r_treeOps;
  assign tree_beta     = r_treeBeta;
  assign tree_valid    = r_treeValid;
  assign rsp_valid     = r_rspValid;
  assign rsp_id        = r_rspId;
  assign rsp_data      = r_rspData;
  assign drain_done    = r_drainDone;
  assign busy          = r_busy;

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Bench for adder_tree_scheduler: a behavioural six-stage adder tree, directed
// stimulus that queues hand-computed responses, and a monitor that pops them.
module tb_adder_tree_scheduler;

  localparam int DW       = 26;
  localparam int NUM_IN   = 7;
  localparam int NUM_REQ  = 4;
  localparam int TREE_LAT = 6;
  localparam int MAX_OUT  = 4;
  localparam int IDW      = 2;

  logic                         clk = 1'b0;
  logic                         GlobalReset;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*NUM_IN*DW-1:0] req_operands;
  logic [NUM_REQ*DW-1:0]        req_beta;
  logic [NUM_REQ-1:0]           req_grant;
  logic [NUM_IN*DW-1:0]         tree_operands;
  logic [DW-1:0]                tree_beta;
  logic                         tree_valid;
  logic [DW-1:0]                tree_result;
  logic                         rsp_valid;
  logic [IDW-1:0]               rsp_id;
  logic [DW-1:0]                rsp_data;
  logic                         drain;
  logic                         drain_done;
  logic                         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int opsTab [NUM_REQ][NUM_IN] = '{
    '{100, 100, 100, 100, 100, 100, 100},
    '{-1, -2, -3, -4, -5, -6, -7},
    '{1, 2, 3, 4, 5, 6, 7},
    '{1000, 2000, 3000, 4000, 5000, 6000, 7000}
  };
  int betaTab [NUM_REQ] = '{-5, 3, 10, 0};
  int sumTab  [NUM_REQ] = '{695, -25, 38, 28000};

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    int             due;
  } exp_t;

  exp_t sbQ[$];
  exp_t popped;

  logic [DW-1:0] treePipe [TREE_LAT];

  adder_tree_scheduler #(
    .DW(DW), .NUM_IN(NUM_IN), .NUM_REQ(NUM_REQ), .TREE_LAT(TREE_LAT), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk),
    .GlobalReset(GlobalReset),
    .req_valid(req_valid),
    .req_operands(req_operands),
    .req_beta(req_beta),
    .req_grant(req_grant),
    .tree_operands(tree_operands),
    .tree_beta(tree_beta),
    .tree_valid(tree_valid),
    .tree_result(tree_result),
    .rsp_valid(rsp_valid),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .drain(drain),
    .drain_done(drain_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] treeSum(input logic [NUM_IN*DW-1:0] ops, input logic [DW-1:0] b);
    int s;
    logic signed [DW-1:0] v;
    v = b;
    s = int'(v);
    for (int j = 0; j < NUM_IN; j++) begin
      v = ops[j*DW +: DW];
      s += int'(v);
    end
    return DW'(s);
  endfunction

  // Stand-in for the real tree: sums every cycle and delays by TREE_LAT edges.
  always @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      for (int s = 0; s < TREE_LAT; s++) treePipe[s] <= '0;
    end else begin
      treePipe[0] <= treeSum(tree_operands, tree_beta);
      for (int s = 1; s < TREE_LAT; s++) treePipe[s] <= treePipe[s-1];
    end
  end

  assign tree_result = treePipe[TREE_LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Drive one cycle's inputs, check the combinational grant and queue the responses it should produce.
  task automatic applyStimulus(input logic [NUM_REQ-1:0] valid, input logic drn,
                               input logic [NUM_REQ-1:0] expGrant, input string name);
    exp_t e;
    req_valid = valid;
    drain     = drn;
    #1;
    checkOutput(name, 64'(req_grant), 64'(expGrant));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (expGrant[i]) begin
        e.id   = IDW'(i);
        e.data = DW'(sumTab[i]);
        e.due  = cyc + 8;
        sbQ.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!GlobalReset && rsp_valid) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL rsp_unexpected: got id %0d data %0h expected no response (cycle %0d)",
                 rsp_id, rsp_data, cyc);
      end else begin
        popped = sbQ.pop_front();
        checkOutput("rsp_id", 64'(rsp_id), 64'(popped.id));
        checkOutput("rsp_data", 64'(rsp_data), 64'(popped.data));
        checkOutput("rsp_cycle", 64'(cyc), 64'(popped.due));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    GlobalReset  = 1'b1;
    req_valid    = '0;
    drain        = 1'b0;
    req_operands = '0;
    req_beta     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_IN; j++) req_operands[(i*NUM_IN + j)*DW +: DW] = DW'(opsTab[i][j]);
      req_beta[i*DW +: DW] = DW'(betaTab[i]);
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_tree_valid", 64'(tree_valid), 64'd0);
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_drain_done", 64'(drain_done), 64'd0);
    GlobalReset = 1'b0;

    $display("[TB] single operation from requester 2");
    applyStimulus(4'b0100, 1'b0, 4'b0100, "single_grant");
    checkOutput("single_tree_valid", 64'(tree_valid), 64'd1);
    checkOutput("single_tree_beta", 64'(tree_beta), 64'd10);
    checkOutput("single_tree_op0", 64'(tree_operands[DW-1:0]), 64'd1);
    checkOutput("single_busy", 64'(busy), 64'd1);
    for (int k = 0; k < 10; k++) applyStimulus(4'b0000, 1'b0, 4'b0000, "single_idle");
    checkOutput("single_busy_after", 64'(busy), 64'd0);

    $display("[TB] full traffic, pointer starts at 3");
    for (int k = 0; k < 12; k++)
      applyStimulus(4'b1111, 1'b0, 4'(1 << ((3 + k) % 4)), "rr_grant");

    $display("[TB] drain during full traffic");
    for (int k = 0; k < 11; k++) begin
      checkOutput("drain_done_timing", 64'(drain_done), (k >= 9) ? 64'd1 : 64'd0);
      applyStimulus(4'b1111, 1'b1, 4'b0000, "drain_nogrant");
    end
    checkOutput("drain_busy", 64'(busy), 64'd0);
    checkOutput("drain_done_held", 64'(drain_done), 64'd1);
    applyStimulus(4'b1111, 1'b0, 4'b0000, "done_release");
    checkOutput("drain_done_clear", 64'(drain_done), 64'd0);
    applyStimulus(4'b1111, 1'b0, 4'b1000, "grant_resume");
    for (int k = 0; k < 10; k++) applyStimulus(4'b0000, 1'b0, 4'b0000, "resume_idle");

    $display("[TB] outstanding limit on requester 1");
    for (int k = 0; k < 14; k++)
      applyStimulus(4'b0010, 1'b0, (k < 4 || (k >= 9 && k <= 12)) ? 4'b0010 : 4'b0000, "maxout_grant");
    for (int k = 0; k < 10; k++) applyStimulus(4'b0000, 1'b0, 4'b0000, "maxout_idle");
    checkOutput("maxout_busy_after", 64'(busy), 64'd0);

    $display("[TB] asynchronous reset with five operations in flight");
    for (int k = 0; k < 5; k++)
      applyStimulus(4'b1111, 1'b0, 4'(1 << ((2 + k) % 4)), "prereset_grant");
    #2;
    sbQ.delete();
    req_valid   = '0;
    GlobalReset = 1'b1;
    #1;
    checkOutput("async_tree_valid", 64'(tree_valid), 64'd0);
    checkOutput("async_tree_beta", 64'(tree_beta), 64'd0);
    checkOutput("async_tree_ops", 64'(tree_operands[DW-1:0]), 64'd0);
    checkOutput("async_rsp_valid", 64'(rsp_valid), 64'd0);
    checkOutput("async_rsp_data", 64'(rsp_data), 64'd0);
    checkOutput("async_busy", 64'(busy), 64'd0);
    checkOutput("async_grant", 64'(req_grant), 64'd0);
    @(negedge clk);
    @(negedge clk);
    GlobalReset = 1'b0;
    for (int k = 0; k < 12; k++) applyStimulus(4'b0000, 1'b0, 4'b0000, "postreset_idle");
    applyStimulus(4'b1111, 1'b0, 4'b0001, "ptr_after_reset");
    for (int k = 0; k < 10; k++) applyStimulus(4'b0000, 1'b0, 4'b0000, "final_idle");

    checkOutput("sb_empty", 64'(sbQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
